// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and helpers for the multiplier issue front-end.
// Select codes live in the shared defines block, guarded so any file may carry it.
`ifndef SEL_DIV_WIDTH
`define SEL_DIV_WIDTH 3
`define SEL_NONE 3'd0
`define SEL_MUL 3'd1
`define SEL_MULW 3'd2
`endif

package mul_issue_ctrl_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } mul_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction
endpackage

// File: rtl/mul_operand_prep.sv
// Combinational operand preparation: word sign-extension, magnitudes,
// result-negate flag and zero-operand detection.
`ifndef SEL_DIV_WIDTH
`define SEL_DIV_WIDTH 3
`define SEL_NONE 3'd0
`define SEL_MUL 3'd1
`define SEL_MULW 3'd2
`endif

module mul_operand_prep
  import mul_issue_ctrl_pkg::*;
(
  input  logic [`SEL_DIV_WIDTH-1:0] i_sig,
  input  logic                      i_signed,
  input  logic [XLEN-1:0]           i_a,
  input  logic [XLEN-1:0]           i_b,
  output logic [XLEN-1:0]           o_mag_a,
  output logic [XLEN-1:0]           o_mag_b,
  output logic                      o_sign,
  output logic                      o_zero
);
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_neg_a;
  logic            w_neg_b;

  assign w_a     = (i_sig == `SEL_MULW) ? sext32(i_a[31:0]) : i_a;
  assign w_b     = (i_sig == `SEL_MULW) ? sext32(i_b[31:0]) : i_b;
  assign w_neg_a = i_signed & w_a[XLEN-1];
  assign w_neg_b = i_signed & w_b[XLEN-1];

  // The most negative value negates to itself; the product is still right mod 2^XLEN.
  assign o_mag_a = w_neg_a ? (~w_a + XLEN'(1)) : w_a;
  assign o_mag_b = w_neg_b ? (~w_b + XLEN'(1)) : w_b;
  assign o_sign  = w_neg_a ^ w_neg_b;
  assign o_zero  = (w_a == '0) | (w_b == '0);
endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the iterative multiplier: accepts a request, drives the
// multiplier until it finishes, and buffers the product for writeback.
`ifndef SEL_DIV_WIDTH
`define SEL_DIV_WIDTH 3
`define SEL_NONE 3'd0
`define SEL_MUL 3'd1
`define SEL_MULW 3'd2
`endif

module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`SEL_DIV_WIDTH-1:0] in_sig,
  input  logic                      in_signed,
  input  logic [XLEN-1:0]           in_a,
  input  logic [XLEN-1:0]           in_b,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_data,
  output logic [XLEN-1:0]           mul_a,
  output logic [XLEN-1:0]           mul_b,
  output logic [`SEL_DIV_WIDTH-1:0] mul_sig,
  output logic                      mul_sign,
  output logic                      mul_hold,
  input  logic [XLEN-1:0]           mul_c,
  input  logic                      mul_busy,
  output mul_state_e                dbg_state
);
  // Handshake: a request transfers on a rising edge where in_valid & in_ready
  // are both high and flush is low; out_data transfers where out_valid & out_ready.
  mul_state_e                r_state;
  logic                      r_discard;
  logic                      r_out_valid;
  logic [XLEN-1:0]           r_out_data;
  logic [XLEN-1:0]           r_mul_a;
  logic [XLEN-1:0]           r_mul_b;
  logic [`SEL_DIV_WIDTH-1:0] r_mul_sig;
  logic                      r_mul_sign;
  logic                      r_mul_hold;

  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_sign;
  logic            w_zero;
  logic            w_accept;
  logic            w_is_mul;
  logic [XLEN-1:0] w_result;

  mul_operand_prep u_prep (
    .i_sig    (in_sig),
    .i_signed (in_signed),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_sign   (w_sign),
    .o_zero   (w_zero)
  );

  assign in_ready = (r_state == ST_IDLE) & reset;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_is_mul = (in_sig == `SEL_MUL) | (in_sig == `SEL_MULW);
  // Word results leave sign-extended from bit 31 whatever the multiplier returns above it.
  assign w_result = (r_mul_sig == `SEL_MULW) ? sext32(mul_c[31:0]) : mul_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_discard   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_sig   <= `SEL_NONE;
      r_mul_sign  <= 1'b0;
      r_mul_hold  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_mul_a    <= w_mag_a;
            r_mul_b    <= w_mag_b;
            r_mul_sign <= w_sign;
            if (w_zero) begin
              r_out_data  <= '0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_mul_sig  <= in_sig;
              r_mul_hold <= 1'b1;
              r_state    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // The multiplier cannot abort, so a flush only marks the result for discard.
          if (flush) r_discard <= 1'b1;
          if (!mul_busy) begin
            r_mul_sig  <= `SEL_NONE;
            r_mul_hold <= 1'b0;
            if (r_discard || flush) begin
              r_state <= ST_DRAIN;
            end else begin
              r_out_data  <= w_result;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready || flush) begin
            r_out_valid <= 1'b0;
            r_discard   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          r_discard <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_sig   = r_mul_sig;
  assign mul_sign  = r_mul_sign;
  assign mul_hold  = r_mul_hold;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl with a behavioural 64-cycle multiplier model.
`ifndef SEL_DIV_WIDTH
`define SEL_DIV_WIDTH 3
`define SEL_NONE 3'd0
`define SEL_MUL 3'd1
`define SEL_MULW 3'd2
`endif

module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [`SEL_DIV_WIDTH-1:0] in_sig = `SEL_NONE;
  logic                      in_signed = 1'b0;
  logic [63:0]               in_a = '0;
  logic [63:0]               in_b = '0;
  logic                      flush = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [63:0]               out_data;
  logic [63:0]               mul_a;
  logic [63:0]               mul_b;
  logic [`SEL_DIV_WIDTH-1:0] mul_sig;
  logic                      mul_sign;
  logic                      mul_hold;
  logic [63:0]               mul_c;
  logic                      mul_busy;
  mul_state_e                dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  mul_issue_ctrl dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .mul_a(mul_a), .mul_b(mul_b), .mul_sig(mul_sig),
    .mul_sign(mul_sign), .mul_hold(mul_hold), .mul_c(mul_c),
    .mul_busy(mul_busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Multiplier model: counts 64 cycles once started, holds its result while mul_hold.
  logic [6:0]  m_cnt;
  int          m_active;
  logic [63:0] m_prod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= '0;
      m_active <= 0;
    end else begin
      if (mul_sig != `SEL_NONE) m_active <= m_active + 1;
      if (mul_sig == `SEL_NONE && !mul_hold) m_cnt <= '0;
      else if (m_cnt < 7'd64) m_cnt <= m_cnt + 7'd1;
    end
  end
  assign m_prod   = mul_a * mul_b;
  assign mul_c    = mul_sign ? (~m_prod + 64'd1) : m_prod;
  assign mul_busy = (mul_sig != `SEL_NONE) && (m_cnt < 7'd64);

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  sig;
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] mag_a;
    logic [63:0] mag_b;
    logic        sign;
    logic [63:0] data;
    int          lat;
  } vec_t;

  // driver: one request; hold = cycles of backpressure, mode 0 out_ready / 1 flush / 2 both
  task automatic run_req(input vec_t v, input int hold, input int mode);
    int          n;
    int          act0;
    int          bad_sig;
    logic [63:0] d0;
    n = 0;
    bad_sig = 0;
    @(negedge clk);
    check64("in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_sig = v.sig; in_signed = v.sgn; in_a = v.a; in_b = v.b;
    act0 = m_active;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    check64("mul_a", mul_a, v.mag_a);
    check64("mul_b", mul_b, v.mag_b);
    check64("mul_sign", {63'd0, mul_sign}, {63'd0, v.sign});
    if (v.lat > 1) begin
      check64("mul_sig_busy", {61'd0, mul_sig}, {61'd0, v.sig});
      check64("mul_hold_busy", {63'd0, mul_hold}, 64'd1);
    end else begin
      check64("mul_sig_idle", {61'd0, mul_sig}, {61'd0, `SEL_NONE});
    end
    while (!out_valid && n < 200) begin
      if (mul_sig != v.sig || !mul_hold) bad_sig++;
      @(negedge clk);
      n++;
    end
    check64("latency", 64'(n), 64'(v.lat));
    if (v.lat > 1) check64("mul_sig_stable", 64'(bad_sig), 64'd0);
    else check64("mul_not_started", 64'(m_active - act0), 64'd0);
    check64("out_data", out_data, v.data);
    d0 = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check64("hold_data", out_data, d0);
      check64("hold_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = (mode != 1);
    flush = (mode != 0);
    @(negedge clk);
    out_ready = 1'b0;
    flush = 1'b0;
    check64("drop_valid", {63'd0, out_valid}, 64'd0);
    check64("back_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
  endtask

  vec_t vecs[10];
  vec_t v;

  initial begin
    int  n;
    bit  saw_drain;
    bit  saw_valid;
    int  drain_n;

    vecs[0] = '{`SEL_MUL,  1'b0, 64'd3, 64'd5, 64'd3, 64'd5, 1'b0, 64'd15, 66};
    vecs[1] = '{`SEL_MUL,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'd7, 64'd6, 1'b1,
                64'hFFFF_FFFF_FFFF_FFD6, 66};
    vecs[2] = '{`SEL_MULW, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'h7FFF_FFFF, 64'd2, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[3] = '{`SEL_MULW, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd5, 64'd1, 64'd5, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFB, 66};
    vecs[4] = '{`SEL_MUL,  1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'h8000_0000_0000_0000,
                64'd2, 1'b0, 64'd0, 66};
    vecs[5] = '{`SEL_MUL,  1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 66};
    vecs[6] = '{`SEL_MUL,  1'b0, 64'd0, 64'h1234, 64'd0, 64'h1234, 1'b0, 64'd0, 1};
    vecs[7] = '{`SEL_MUL,  1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC,
                64'd3, 64'd4, 1'b0, 64'd12, 66};
    vecs[8] = '{`SEL_MULW, 1'b0, 64'hDEAD_BEEF_0000_0003, 64'h0000_0001_0000_0004,
                64'd3, 64'd4, 1'b0, 64'd12, 66};
    vecs[9] = '{`SEL_MULW, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'd7, 64'd0, 64'd7, 1'b0, 64'd0, 1};

    // reset state
    #1;
    check64("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check64("rst_out_data", out_data, 64'd0);
    check64("rst_mul_sig", {61'd0, mul_sig}, {61'd0, `SEL_NONE});
    check64("rst_mul_hold", {63'd0, mul_hold}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_req(vecs[i], 0, 0);

    // zero shortcut under backpressure
    run_req(vecs[6], 10, 0);
    // flush while result is held, and flush together with out_ready
    run_req(vecs[9], 2, 1);
    run_req(vecs[0], 0, 2);

    // unsupported select code is ignored
    @(negedge clk);
    in_valid = 1'b1; in_sig = 3'd5; in_signed = 1'b0; in_a = 64'd2; in_b = 64'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check64("bad_sig_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check64("bad_sig_hold", {63'd0, mul_hold}, 64'd0);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; in_sig = `SEL_MUL; in_a = 64'd2; in_b = 64'd2; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check64("idle_flush_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check64("idle_flush_valid", {63'd0, out_valid}, 64'd0);

    // flush at T+20 of 9 x 9: result discarded through DRAIN
    @(negedge clk);
    in_valid = 1'b1; in_sig = `SEL_MUL; in_signed = 1'b0; in_a = 64'd9; in_b = 64'd9;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (n < 20) begin @(negedge clk); n++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n++;
    saw_drain = 1'b0; saw_valid = 1'b0; drain_n = 0;
    while (dbg_state != ST_IDLE && n < 200) begin
      if (dbg_state == ST_DRAIN) begin saw_drain = 1'b1; drain_n = n; end
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    check64("flush_no_valid", {63'd0, saw_valid}, 64'd0);
    check64("flush_drain", {63'd0, saw_drain}, 64'd1);
    check64("flush_drain_cycle", 64'(drain_n), 64'd66);
    check64("flush_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    v = '{`SEL_MUL, 1'b0, 64'd4, 64'd4, 64'd4, 64'd4, 1'b0, 64'd16, 66};
    run_req(v, 0, 0);

    // asynchronous reset in the middle of BUSY
    @(negedge clk);
    in_valid = 1'b1; in_sig = `SEL_MUL; in_signed = 1'b1;
    in_a = 64'hFFFF_FFFF_FFFF_FFF9; in_b = 64'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check64("pre_rst_busy", {62'd0, dbg_state}, {62'd0, ST_BUSY});
    rst_n = 1'b0;
    #1;
    check64("mid_rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check64("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check64("mid_rst_out_data", out_data, 64'd0);
    check64("mid_rst_mul_a", mul_a, 64'd0);
    check64("mid_rst_mul_b", mul_b, 64'd0);
    check64("mid_rst_mul_sig", {61'd0, mul_sig}, {61'd0, `SEL_NONE});
    check64("mid_rst_mul_sign", {63'd0, mul_sign}, 64'd0);
    check64("mid_rst_mul_hold", {63'd0, mul_hold}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(vecs[0], 0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Execute-stage front-end for the iterative 64-bit multiplier. Accepts a multiply request from execute over a valid/ready handshake, then prepares the operands as sign-extended magnitudes plus a result-negate flag. It drives and holds the multiplier control lines until the multiplier finishes, and keeps the result in a one-entry buffer until writeback accepts it. It also handles zero-operand shortcuts and pipeline flushes, so execute never deals with multiplier timing.

## Interface
- XLEN, 64, datapath width
- SEL_W, `SEL_DIV_WIDTH, width of the operation-select code
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid & in_ready; equals (state==IDLE)
- in_sig  in  SEL_W  `SEL_MUL or `SEL_MULW
- in_signed  in  1  treat operands as two's complement
- in_a, in_b  in  XLEN  raw operands
- flush  in  1  discard the in-flight request
- out_valid  out  1  result held in buffer
- out_ready  in  1  consumer takes result
- out_data  out  XLEN  product; MULW results are already sign-extended from bit 31
- mul_a, mul_b  out  XLEN  operand magnitudes to the multiplier
- mul_sig  out  SEL_W  select code to the multiplier; `SEL_NONE when idle
- mul_sign  out  1  multiplier negates its final result
- mul_hold  out  1  stall to the multiplier; holds its finished result
- mul_c  in  XLEN  multiplier result
- mul_busy  in  1  multiplier still counting (its stall output)

## Operation
- States: IDLE, BUSY, DONE, DRAIN.
- **IDLE.** On handshake, register the prepared operands.
  - If in_sig is not MUL or MULW, the request is ignored and the state stays IDLE.
  - If either prepared operand is zero, load out_data=0 and go to DONE.
  - Otherwise go to BUSY.
- **Operand prep:**
  - MULW: sign-extend both operands from bit 31.
  - neg_x = in_signed & x[XLEN-1].
  - mag_x = neg_x ? ~x+1 : x. 0x8000…0 maps to itself; the product stays correct mod 2^64.
  - mul_sign = neg_a ^ neg_b.
- **BUSY.**
  - Drive mul_sig = the request's code and mul_hold=1.
  - When mul_busy==0, capture mul_c into out_data, then go to DONE. If the discard flag is set, go to DRAIN instead.
- **DONE.**
  - mul_sig=`SEL_NONE, mul_hold=0, which releases the multiplier to its init state at the next edge.
  - out_valid=1 with out_data stable.
  - On out_ready, go to IDLE.
- **DRAIN.** Lasts one cycle with mul_sig=`SEL_NONE and mul_hold=0, then go to IDLE. out_valid stays 0.
- **Flush:**
  - IDLE: no request is accepted that cycle.
  - BUSY: set the discard flag. The multiplier cannot be aborted mid-count, so the block waits for it to finish.
  - DONE: drop the result and go to IDLE.
  - Flush in the same cycle as out_ready in DONE: go to IDLE; the result counts as consumed.
- The discard flag clears on entry to IDLE.

## Timing
- **Reset values:** state=IDLE, out_valid=0, out_data=0, mul_a=mul_b=0, mul_sig=`SEL_NONE, mul_sign=0, mul_hold=0, discard=0. in_ready=0 while reset is low.
- **Normal latency:** accept in cycle T; BUSY from T+1; with the 64-cycle multiplier, mul_busy falls in T+65 and out_valid rises in T+66.
- **Zero shortcut:** out_valid in T+1.
- **Back-to-back:** the earliest next accept is the cycle after DONE/DRAIN exits. This guarantees the multiplier sees `SEL_NONE for at least one cycle between requests.
- mul_* outputs are registered and stay constant for the whole of BUSY.
- out_data and out_valid are registered and stay stable while out_valid & ~out_ready.

## Structure
- Shared package: a state enum type for this block; XLEN is taken from the common package. SEL codes stay in the existing defines file.
- Sub-module mul_operand_prep: combinational sign-extend / magnitude / sign logic, reused later by the divider front-end.
- Everything else (FSM, operand registers, result buffer) lives in mul_issue_ctrl.

## Test plan
- **Reset:** assert reset mid-BUSY -> outputs return to their reset values immediately; after release, a new request works.
- **Unsigned MUL:** 3 × 5 -> out_data=15 with out_valid in T+66; mul_sig held constant throughout BUSY.
- **Signed MUL:** −7 × 6 -> mul_a=7, mul_b=6, mul_sign=1; out_data=0xFFFF_FFFF_FFFF_FFD6.
- **MULW:** 0x7FFF_FFFF × 2 -> out_data=0xFFFF_FFFF_FFFF_FFFE.
- **Zero shortcut and backpressure:** 0 × 0x1234 -> out_data=0, out_valid in T+1, multiplier never started. Then hold out_ready low for 10 cycles -> out_data stable; accepted only after out_ready rises.
- **Flush:** flush at T+20 of 9 × 9 -> no out_valid, DRAIN occurs. The next request 4 × 4 returns 16 with correct latency.
